// File: rtl/nl2_dbank_wr_seq_if.sv
// nl2_dbank_wr_seq_if
//   Cluster-side write-beat handshake into the staggered dbank write sequencer.
//   Optional byte mask (wr_mask) is present only when NL2_DBANK_WR_MASK_EN is defined.
//
//   wr_valid  master->slave  beat valid
//   wr_ready  slave->master  beat accepted when wr_valid & wr_ready
//   wr_addr   master->slave  row address, sampled on beat 0 only
//   wr_data   master->slave  beat payload
//   wr_last   master->slave  final beat of row
//   wr_mask   master->slave  byte write mask (NL2_DBANK_WR_MASK_EN only)
interface nl2_dbank_wr_seq_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 12
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
`ifdef NL2_DBANK_WR_MASK_EN
    logic [DATA_W/8-1:0] wr_mask;
`endif

    modport master (
`ifdef NL2_DBANK_WR_MASK_EN
        output wr_mask,
`endif
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
`ifdef NL2_DBANK_WR_MASK_EN
        input  wr_mask,
`endif
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/nl2_dbank_wr_seq.sv
// nl2_dbank_wr_seq
//   Splits each N_SRAM-beat row write into per-sub-bank writes for a set of
//   staggered-clock SRAM sub-banks. Beat k is parked in sub-bank k's holding
//   register and presented (sram_we[k]) until that sub-bank's clock edge
//   arrives with the data having been stable for a full dbank_clk cycle.
//
//   Optional feature macro: NL2_DBANK_WR_MASK_EN (adds wr_mask / sram_wmask).
//
// Ports
//   dbank_clk          ungated dbank clock
//   rst_a_n            asynchronous active-low reset
//   wr_if              write-beat handshake (slave modport)
//   dbank_accept_en    write-accept enable from clock distributor
//   dbank_active_next  bit k: sub-bank k posedge follows next dbank_clk edge
//   sram_we            per-sub-bank write enable
//   sram_addr          per-sub-bank row address, slice k
//   sram_wdata         per-sub-bank write data, slice k
//   sram_wmask         per-sub-bank byte mask, slice k (NL2_DBANK_WR_MASK_EN only)
//   dbank_idle         registered: no work pending
//   seq_err            sticky protocol error (wr_last misplaced)
//
// state | meaning
// IDLE  | no row in flight, waiting for beat 0
// BURST | row in progress, beats 1..N_SRAM-1 still to accept
// DRAIN | all beats accepted, waiting for every sub-bank to consume its beat
module nl2_dbank_wr_seq #(
    parameter int N_SRAM = 4,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 12
) (
    input  logic                       dbank_clk,
    input  logic                       rst_a_n,
    nl2_dbank_wr_seq_if.slave          wr_if,
    input  logic                       dbank_accept_en,
    input  logic [N_SRAM-1:0]          dbank_active_next,
    output logic [N_SRAM-1:0]          sram_we,
    output logic [N_SRAM*ADDR_W-1:0]   sram_addr,
    output logic [N_SRAM*DATA_W-1:0]   sram_wdata,
`ifdef NL2_DBANK_WR_MASK_EN
    output logic [N_SRAM*DATA_W/8-1:0] sram_wmask,
`endif
    output logic                       dbank_idle,
    output logic                       seq_err
);

    localparam int CNT_W = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_SRAM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 beat_cnt_q, beat_cnt_d;
    logic [N_SRAM-1:0]                pend_q, pend_d;
    logic [N_SRAM-1:0]                pend_old_q, pend_old_d;
    logic [ADDR_W-1:0]                row_addr_q, row_addr_d;
    logic [N_SRAM-1:0][ADDR_W-1:0]    sram_addr_q, sram_addr_d;
    logic [N_SRAM-1:0][DATA_W-1:0]    sram_wdata_q, sram_wdata_d;
`ifdef NL2_DBANK_WR_MASK_EN
    logic [N_SRAM-1:0][DATA_W/8-1:0]  sram_wmask_q, sram_wmask_d;
`endif
    logic                             seq_err_q, seq_err_d;
    logic                             dbank_idle_q, dbank_idle_d;

    logic                             wr_ready;
    logic                             accept;
    logic                             is_last;
    logic [N_SRAM-1:0]                pend_clr;

    // Accepting only into a free holding slot means a slot can never be set
    // and cleared on the same edge.
    assign wr_ready = dbank_accept_en & ~pend_q[beat_cnt_q] & (state_q != DRAIN);
    assign accept   = wr_if.wr_valid & wr_ready;
    assign is_last  = (beat_cnt_q == LAST_BEAT);

    // pend_old marks slots whose data has already been driven for a full
    // cycle; only those may retire on the sub-bank's edge.
    assign pend_clr = dbank_active_next & pend_q & pend_old_q;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        pend_d       = pend_q & ~pend_clr;
        pend_old_d   = pend_q;
        row_addr_d   = row_addr_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
`ifdef NL2_DBANK_WR_MASK_EN
        sram_wmask_d = sram_wmask_q;
`endif
        seq_err_d    = seq_err_q;

        if (accept) begin
            pend_d[beat_cnt_q]       = 1'b1;
            sram_wdata_d[beat_cnt_q] = wr_if.wr_data;
`ifdef NL2_DBANK_WR_MASK_EN
            sram_wmask_d[beat_cnt_q] = wr_if.wr_mask;
`endif
            if (beat_cnt_q == '0) begin
                sram_addr_d[beat_cnt_q] = wr_if.wr_addr;
                row_addr_d              = wr_if.wr_addr;
            end else begin
                sram_addr_d[beat_cnt_q] = row_addr_q;
            end
            // A misplaced wr_last is flagged but the beat still lands and
            // the row keeps its fixed length.
            if (wr_if.wr_last != is_last) begin
                seq_err_d = 1'b1;
            end
            beat_cnt_d = is_last ? '0 : beat_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (accept && is_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pend_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        dbank_idle_d = (state_d == IDLE) && (pend_d == '0) && !wr_if.wr_valid;
    end

    always_ff @(posedge dbank_clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            pend_q       <= '0;
            pend_old_q   <= '0;
            row_addr_q   <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
`ifdef NL2_DBANK_WR_MASK_EN
            sram_wmask_q <= '0;
`endif
            seq_err_q    <= 1'b0;
            dbank_idle_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            pend_q       <= pend_d;
            pend_old_q   <= pend_old_d;
            row_addr_q   <= row_addr_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
`ifdef NL2_DBANK_WR_MASK_EN
            sram_wmask_q <= sram_wmask_d;
`endif
            seq_err_q    <= seq_err_d;
            dbank_idle_q <= dbank_idle_d;
        end
    end

    assign wr_if.wr_ready = wr_ready;
    assign sram_we        = pend_q;
    assign sram_addr      = sram_addr_q;
    assign sram_wdata     = sram_wdata_q;
`ifdef NL2_DBANK_WR_MASK_EN
    assign sram_wmask     = sram_wmask_q;
`endif
    assign dbank_idle     = dbank_idle_q;
    assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_nl2_dbank_wr_seq.sv
// tb_nl2_dbank_wr_seq
//   Directed bench for nl2_dbank_wr_seq with N_SRAM=4, DATA_W=128, ADDR_W=12.
//   dbank_active_next rotates one-hot every cycle to model the staggered
//   sub-bank clocks. Mask scenario is built only with NL2_DBANK_WR_MASK_EN.
module tb_nl2_dbank_wr_seq;

    localparam int NS = 4;
    localparam int DW = 128;
    localparam int AW = 12;
    localparam int MAX_WAIT = 40;

    logic                 dbank_clk;
    logic                 rst_a_n;
    logic                 dbank_accept_en;
    logic [NS-1:0]        dbank_active_next;
    logic [NS-1:0]        sram_we;
    logic [NS*AW-1:0]     sram_addr;
    logic [NS*DW-1:0]     sram_wdata;
`ifdef NL2_DBANK_WR_MASK_EN
    logic [NS*DW/8-1:0]   sram_wmask;
`endif
    logic                 dbank_idle;
    logic                 seq_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic rot_en;

    nl2_dbank_wr_seq_if #(.DATA_W(DW), .ADDR_W(AW)) wr_if ();

    nl2_dbank_wr_seq #(.N_SRAM(NS), .DATA_W(DW), .ADDR_W(AW)) dut (
        .dbank_clk         (dbank_clk),
        .rst_a_n           (rst_a_n),
        .wr_if             (wr_if),
        .dbank_accept_en   (dbank_accept_en),
        .dbank_active_next (dbank_active_next),
        .sram_we           (sram_we),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
`ifdef NL2_DBANK_WR_MASK_EN
        .sram_wmask        (sram_wmask),
`endif
        .dbank_idle        (dbank_idle),
        .seq_err           (seq_err)
    );

    initial dbank_clk = 1'b0;
    always #5 dbank_clk = ~dbank_clk;

    function automatic logic [DW-1:0] mk(input logic [7:0] tag, input int k);
        return {4{tag, 8'(k), 16'h5A5A}};
    endfunction

    function automatic logic [AW-1:0] addr_of(input int k);
        return sram_addr[k*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] data_of(input int k);
        return sram_wdata[k*DW +: DW];
    endfunction

    task automatic step();
        @(posedge dbank_clk);
        #1;
        if (rot_en) dbank_active_next = {dbank_active_next[NS-2:0], dbank_active_next[NS-1]};
    endtask

    // Present one beat, wait (bounded) for wr_ready, then clock it in.
    task automatic send_beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic last, output int stalls);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        wr_if.wr_last  = last;
        #1;
        stalls = 0;
        while (!wr_if.wr_ready && stalls < MAX_WAIT) begin
            step();
            stalls++;
        end
        if (stalls >= MAX_WAIT) begin
            n_tests++; n_fail++;
            $display("FAIL beat_accept_timeout: wr_ready stayed 0 for %0d cycles, required 1", stalls);
        end else begin
            step();
        end
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        wr_if.wr_valid = 1'b0;
        n = 0;
        while (!dbank_idle && n < 60) begin
            step();
            n++;
        end
        n_tests++;
        if (dbank_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_idle: dbank_idle=%b after %0d cycles, required 1", dbank_idle, n);
        end
    endtask

    task automatic test_reset();
        rst_a_n           = 1'b0;
        rot_en            = 1'b1;
        dbank_accept_en   = 1'b1;
        dbank_active_next = 4'b0001;
        wr_if.wr_valid    = 1'b0;
        wr_if.wr_addr     = '0;
        wr_if.wr_data     = '0;
        wr_if.wr_last     = 1'b0;
`ifdef NL2_DBANK_WR_MASK_EN
        wr_if.wr_mask     = '1;
`endif
        #12;
        n_tests++;
        if (sram_we !== 4'b0000) begin n_fail++; $display("FAIL reset_we: got %b, required 0000", sram_we); end
        n_tests++;
        if (dbank_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b, required 1", dbank_idle); end
        n_tests++;
        if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err: got %b, required 0", seq_err); end
        n_tests++;
        if (sram_addr !== '0 || sram_wdata !== '0) begin
            n_fail++; $display("FAIL reset_addr_data: addr=%h, required 0", sram_addr);
        end
        @(negedge dbank_clk);
        rst_a_n = 1'b1;
        step();
        n_tests++;
        if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", wr_if.wr_ready); end
    endtask

    // Rotation phase chosen so every sub-bank edge comes exactly two cycles
    // after its beat is accepted.
    task automatic test_basic_row();
        dbank_active_next = 4'b0100;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 12'h005; wr_if.wr_last = 1'b0;
        wr_if.wr_data  = mk(8'hD0, 0);
        step();
        n_tests++;
        if (sram_we !== 4'b0001 || dbank_idle !== 1'b0) begin
            n_fail++; $display("FAIL basic_e0: we=%b idle=%b, required 0001 0", sram_we, dbank_idle);
        end
        wr_if.wr_data = mk(8'hD0, 1);
        step();
        n_tests++;
        if (sram_we !== 4'b0011 || addr_of(0) !== 12'h005 || addr_of(1) !== 12'h005 ||
            data_of(0) !== mk(8'hD0, 0) || data_of(1) !== mk(8'hD0, 1)) begin
            n_fail++; $display("FAIL basic_e1: we=%b addr0=%h addr1=%h, required 0011 005 005", sram_we, addr_of(0), addr_of(1));
        end
        wr_if.wr_data = mk(8'hD0, 2);
        step();
        n_tests++;
        if (sram_we !== 4'b0110) begin n_fail++; $display("FAIL basic_e2: we=%b, required 0110", sram_we); end
        wr_if.wr_data = mk(8'hD0, 3); wr_if.wr_last = 1'b1;
        step();
        n_tests++;
        if (sram_we !== 4'b1100 || addr_of(2) !== 12'h005 || addr_of(3) !== 12'h005 ||
            data_of(2) !== mk(8'hD0, 2) || data_of(3) !== mk(8'hD0, 3)) begin
            n_fail++; $display("FAIL basic_e3: we=%b addr2=%h addr3=%h, required 1100 005 005", sram_we, addr_of(2), addr_of(3));
        end
        wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
        #1;
        n_tests++;
        if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL basic_drain_ready: got %b, required 0", wr_if.wr_ready); end
        step();
        n_tests++;
        if (sram_we !== 4'b1000) begin n_fail++; $display("FAIL basic_e4: we=%b, required 1000", sram_we); end
        step();
        n_tests++;
        if (sram_we !== 4'b0000 || dbank_idle !== 1'b0) begin
            n_fail++; $display("FAIL basic_e5: we=%b idle=%b, required 0000 0", sram_we, dbank_idle);
        end
        step();
        n_tests++;
        if (dbank_idle !== 1'b1 || seq_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_e6: idle=%b seq_err=%b, required 1 0", dbank_idle, seq_err);
        end
    endtask

    task automatic test_seq_err();
        int s;
        send_beat(12'h010, mk(8'hE1, 0), 1'b0, s);
        n_tests++;
        if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_err_early: got %b, required 0", seq_err); end
        send_beat(12'h010, mk(8'hE1, 1), 1'b1, s);
        n_tests++;
        if (seq_err !== 1'b1 || sram_we[1] !== 1'b1 || data_of(1) !== mk(8'hE1, 1)) begin
            n_fail++; $display("FAIL seq_err_set: seq_err=%b we1=%b, required 1 1", seq_err, sram_we[1]);
        end
        send_beat(12'h010, mk(8'hE1, 2), 1'b0, s);
        send_beat(12'h010, mk(8'hE1, 3), 1'b1, s);
        wait_idle();
        for (int k = 0; k < NS; k++) send_beat(12'h011, mk(8'hE2, k), (k == NS-1), s);
        wait_idle();
        n_tests++;
        if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_err_sticky: got %b, required 1", seq_err); end
    endtask

    task automatic test_stall();
        int s;
        int bad;
        send_beat(12'h020, mk(8'hA5, 0), 1'b0, s);
        send_beat(12'h020, mk(8'hA5, 1), 1'b0, s);
        dbank_accept_en = 1'b0;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 12'h3FF; wr_if.wr_data = mk(8'hA5, 2);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (wr_if.wr_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready_c%0d: got %b, required 0", c, wr_if.wr_ready);
            end
            step();
        end
        dbank_accept_en = 1'b1;
        send_beat(12'h3FF, mk(8'hA5, 2), 1'b0, s);
        n_tests++;
        if (sram_we[2] !== 1'b1 || addr_of(2) !== 12'h020 || data_of(2) !== mk(8'hA5, 2)) begin
            n_fail++; $display("FAIL stall_beat2: we2=%b addr2=%h, required 1 020", sram_we[2], addr_of(2));
        end
        send_beat(12'h3FF, mk(8'hA5, 3), 1'b1, s);
        n_tests++;
        if (sram_we[3] !== 1'b1 || addr_of(3) !== 12'h020 || data_of(3) !== mk(8'hA5, 3)) begin
            n_fail++; $display("FAIL stall_beat3: we3=%b addr3=%h, required 1 020", sram_we[3], addr_of(3));
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int s;
        int n;
        int hold_bad;
        for (int k = 0; k < NS; k++) send_beat(12'h005, mk(8'hB1, k), (k == NS-1), s);
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 12'h006; wr_if.wr_data = mk(8'hB2, 0); wr_if.wr_last = 1'b0;
        #1;
        n_tests++;
        if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: ready=%b, required 0", wr_if.wr_ready); end
        n = 0;
        hold_bad = 0;
        while (!wr_if.wr_ready && n < MAX_WAIT) begin
            for (int k = 0; k < NS; k++) begin
                if (sram_we[k] && (data_of(k) !== mk(8'hB1, k) || addr_of(k) !== 12'h005)) hold_bad++;
            end
            step();
            n++;
        end
        n_tests++;
        if (hold_bad != 0) begin n_fail++; $display("FAIL b2b_hold: %0d overwritten held slots, required 0", hold_bad); end
        n_tests++;
        if (n < 1 || n >= MAX_WAIT || sram_we !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_release: waited %0d we=%b, required 1..39 0000", n, sram_we);
        end
        step();
        wr_if.wr_valid = 1'b0;
        n_tests++;
        if (sram_we !== 4'b0001 || addr_of(0) !== 12'h006 || data_of(0) !== mk(8'hB2, 0)) begin
            n_fail++; $display("FAIL b2b_row2_beat0: we=%b addr0=%h, required 0001 006", sram_we, addr_of(0));
        end
        for (int k = 1; k < NS; k++) send_beat(12'h006, mk(8'hB2, k), (k == NS-1), s);
        wait_idle();
    endtask

    task automatic test_reset_mid_row();
        int s;
        int seen;
        for (int k = 0; k < 3; k++) send_beat(12'h030, mk(8'hC3, k), 1'b0, s);
        #2;
        rst_a_n = 1'b0;
        #1;
        n_tests++;
        if (sram_we !== 4'b0000 || dbank_idle !== 1'b1 || seq_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: we=%b idle=%b seq_err=%b, required 0000 1 0", sram_we, dbank_idle, seq_err);
        end
        @(negedge dbank_clk);
        rst_a_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (sram_we !== 4'b0000) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_no_we: %0d cycles with we set, required 0", seen); end
        send_beat(12'h007, mk(8'hC4, 0), 1'b0, s);
        n_tests++;
        if (sram_we !== 4'b0001 || addr_of(0) !== 12'h007) begin
            n_fail++; $display("FAIL rst_new_row: we=%b addr0=%h, required 0001 007", sram_we, addr_of(0));
        end
        for (int k = 1; k < NS; k++) send_beat(12'h007, mk(8'hC4, k), (k == NS-1), s);
        wait_idle();
        n_tests++;
        if (seq_err !== 1'b0) begin n_fail++; $display("FAIL rst_row_clean: seq_err=%b, required 0", seq_err); end
    endtask

`ifdef NL2_DBANK_WR_MASK_EN
    task automatic test_mask();
        int s;
        for (int k = 0; k < NS; k++) begin
            wr_if.wr_mask = (k == NS-1) ? 16'h00FF : 16'hFFFF;
            send_beat(12'h040, mk(8'hF0, k), (k == NS-1), s);
        end
        n_tests++;
        if (sram_we[3] !== 1'b1 || sram_wmask[3*16 +: 16] !== 16'h00FF || sram_wmask[2*16 +: 16] !== 16'hFFFF) begin
            n_fail++; $display("FAIL mask_beat3: we3=%b mask3=%h mask2=%h, required 1 00ff ffff",
                               sram_we[3], sram_wmask[3*16 +: 16], sram_wmask[2*16 +: 16]);
        end
        wait_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_row();
        test_seq_err();
        test_stall();
        test_back_to_back();
        test_reset_mid_row();
`ifdef NL2_DBANK_WR_MASK_EN
        test_mask();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nl2_dbank_wr_seq.md
NL2_DBANK_WR_SEQ -- requirements
Module: nl2_dbank_wr_seq

Interface
REQ-001 SHALL have parameters: N_SRAM, default 4, legal {2,4}, number of staggered sub-banks; DATA_W, default 128, beat and sub-bank word width; ADDR_W, default 12, sub-bank row address width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- dbank_clk  in  1  single clock, ungated dbank clock
- rst_a_n  in  1  asynchronous active-low reset
- wr_valid  in  1  cluster write beat valid
- wr_ready  out  1  beat accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_W  row address, sampled on beat 0 only
- wr_data  in  DATA_W  beat payload
- wr_last  in  1  final beat of row
- dbank_accept_en  in  1  write-accept enable from clock distributor
- dbank_active_next  in  N_SRAM  sub-bank k posedge follows next dbank_clk edge
- sram_we  out  N_SRAM  per-sub-bank write enable
- sram_addr  out  N_SRAM*ADDR_W  per-sub-bank address, slice k
- sram_wdata  out  N_SRAM*DATA_W  per-sub-bank data, slice k
- dbank_idle  out  1  to clock distributor; no work pending
- seq_err  out  1  sticky protocol error

Function
REQ-003 A row SHALL be exactly N_SRAM beats; beat k SHALL go only to sub-bank k.
REQ-004 beat_cnt SHALL be log2(N_SRAM) bits, increment on each accepted beat, and wrap N_SRAM-1 -> 0.
REQ-005 wr_ready SHALL be combinational = dbank_accept_en & ~pend[beat_cnt] & (state != DRAIN).
REQ-006 On an accepted beat k: sram_wdata[k] <= wr_data; sram_addr[k] <= (k==0 ? wr_addr : row_addr_r); pend[k] <= 1; on k==0 row_addr_r <= wr_addr.
REQ-007 pend[k] SHALL clear on a dbank_clk edge where dbank_active_next[k]==1, pend[k]==1, and pend[k] was already 1 on the previous edge (data held one full cycle before the sub-bank edge).
REQ-008 sram_we[k] SHALL equal pend[k]; sram_addr[k]/sram_wdata[k] SHALL hold unchanged while pend[k]==1.
REQ-009 Same-edge set and clear of pend[k] SHALL NOT occur (REQ-005 blocks accept while pend set).
REQ-010 FSM states: IDLE, BURST, DRAIN.
- IDLE -> BURST on accepted beat 0 (N_SRAM>1 always).
- BURST -> DRAIN on accepted beat N_SRAM-1.
- DRAIN -> IDLE when pend==0; DRAIN -> BURST never directly.
REQ-011 wr_last==1 on beat k != N_SRAM-1, or wr_last==0 on beat N_SRAM-1, SHALL set seq_err; the beat is still written and counting is unchanged.
REQ-012 seq_err SHALL stay set until reset.
REQ-013 dbank_idle SHALL be registered: 1 iff next state IDLE, pend==0 and wr_valid==0 on that edge.
REQ-014 dbank_accept_en low mid-row SHALL stall acceptance with no loss of beat_cnt, row_addr_r or pend.

Reset
REQ-015 rst_a_n low SHALL asynchronously force: state IDLE, beat_cnt 0, pend 0, sram_we 0, sram_addr 0, sram_wdata 0, row_addr_r 0, seq_err 0, dbank_idle 1.
REQ-016 Reset mid-row SHALL discard the partial row; no sram_we SHALL assert until a new beat 0 is accepted.

Configuration
REQ-017 Macro NL2_DBANK_WR_MASK_EN defined: SHALL add input wr_mask (DATA_W/8) and output sram_wmask (N_SRAM*DATA_W/8), captured and held per REQ-006/REQ-008.
REQ-018 Macro undefined: ports wr_mask and sram_wmask SHALL be absent; sub-banks write full words.

Verification
REQ-019 N_SRAM=4, accept_en=1, active_next rotating one-hot 0001->0010->0100->1000, 4 beats D0..D3, addr 0x05 -> each sram_we[k] high 2 cycles, sram_addr[k]=0x05, sram_wdata[k]=Dk, seq_err=0.
REQ-020 wr_last=1 on beat 1 -> seq_err=1 from next edge, persists through the next clean row.
REQ-021 accept_en drops after beat 1 for 5 cycles -> wr_ready=0 for those cycles; beats 2,3 land on sub-banks 2,3 with row address unchanged.
REQ-022 Back-to-back rows, second at 0x06 -> beat 0 of row 2 stalls until pend[0]=0; no overwrite of held row-1 data.
REQ-023 rst_a_n pulsed low after beat 2 -> all sram_we 0 immediately, dbank_idle=1; next row starts at beat 0.
REQ-024 NL2_DBANK_WR_MASK_EN defined, wr_mask=16'h00FF on beat 3 -> sram_wmask[3]=16'h00FF while sram_we[3]=1.
